// File: rtl/fetch_sequencer_if.sv
// Purpose: bundles the fetch sequencer's RAM port, issue handshake, redirect/halt controls and status flags.
// Latency: none (wires only).
// Backpressure: inst_valid/inst_ready handshake on the issue side; the RAM side has none.
//
// Ports (seen from the sequencer, modport master):
//   in : start, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt_req
//   out: imem_ren, imem_addr, inst_out, inst_valid, pc_out, pc_plus4, halted, misalign_err
// The slave modport is the mirror image, used by the RAM/datapath side.
interface fetch_sequencer_if #(
    parameter int IMEM_AW = 12
);
    logic               start;
    logic               imem_ren;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        inst_out;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        pc_out;
    logic [31:0]        pc_plus4;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt_req;
    logic               halted;
    logic               misalign_err;

    modport master (
        input  start, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt_req,
        output imem_ren, imem_addr, inst_out, inst_valid, pc_out, pc_plus4, halted, misalign_err
    );

    modport slave (
        output start, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt_req,
        input  imem_ren, imem_addr, inst_out, inst_valid, pc_out, pc_plus4, halted, misalign_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Purpose: multi-cycle instruction fetch controller; owns the PC, reads the sync RAM, issues one instruction at a time.
// Latency: 3 cycles per instruction minimum (FETCH -> WAIT -> ISSUE with ready high).
// Backpressure: inst_out/pc_out held in ISSUE while inst_ready is low; no RAM reads happen meanwhile.
//
// Ports:
//   clck, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus         : fetch_sequencer_if master modport (RAM read port, issue handshake,
//                 redirect/halt controls, halted and sticky misalign_err flags)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic             clck,
    input  logic             rst_n,
    fetch_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_q;
    logic        err_q, err_nxt;
    logic        handshake;
    logic        target_misaligned;

    assign handshake         = (state == S_ISSUE) && bus.inst_ready;
    assign target_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        err_nxt   = err_q;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                // Redirect and halt belong to the instruction being retired, so
                // they are only looked at on the handshake cycle.
                if (handshake) begin
                    if (target_misaligned) begin
                        // PC is left pointing at the offending instruction for debug.
                        state_nxt = S_ERROR;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt    = bus.redirect_valid ? bus.redirect_pc : pc + 32'd4;
                        // HALT keeps the already-updated PC so resume fetches the successor.
                        state_nxt = bus.halt_req ? S_HALT : S_FETCH;
                    end
                end
            end
            S_HALT:  if (bus.start) state_nxt = S_FETCH;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            inst_q <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            err_q <= err_nxt;
            if (state == S_WAIT) begin
                inst_q <= bus.imem_rdata;
            end
        end
    end

    // All outputs decode directly from registers, so an asserted reset clears
    // them in the same cycle and any in-flight RAM data is simply never captured.
    assign bus.imem_ren     = (state == S_FETCH);
    assign bus.imem_addr    = pc[IMEM_AW+1:2];
    assign bus.inst_out     = inst_q;
    assign bus.inst_valid   = (state == S_ISSUE);
    assign bus.pc_out       = pc;
    assign bus.pc_plus4     = pc + 32'd4;
    assign bus.halted       = (state == S_HALT);
    assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: randomized self-checking bench for fetch_sequencer against a transaction-level model.
// Latency: model tracks cycles-until-issue after each start/handshake.
// Backpressure: inst_ready is randomized; held outputs are checked every cycle.
module tb_fetch_sequencer;

    localparam int          AW     = 6;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clck  = 1'b0;
    logic rst_n = 1'b0;

    always #5 clck = ~clck;

    fetch_sequencer_if #(.IMEM_AW(AW)) bus  ();
    fetch_sequencer_if #(.IMEM_AW(AW)) wbus ();

    fetch_sequencer #(.RESET_PC(RST_PC), .IMEM_AW(AW)) u_dut (
        .clck  (clck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(AW)) u_dut_wrap (
        .clck  (clck),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    logic [31:0] mem [DEPTH];

    // Synchronous instruction RAM shared by both instances.
    always @(posedge clck) begin
        if (bus.imem_ren)  bus.imem_rdata  <= mem[bus.imem_addr];
        if (wbus.imem_ren) wbus.imem_rdata <= mem[wbus.imem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: abstract run mode, PC of the next instruction to issue,
    // and how many cycles remain until that instruction is presented.
    typedef enum {M_IDLE, M_RUN, M_HALT, M_ERR} mode_t;
    mode_t       mode;
    int          wait_n;
    logic [31:0] exp_pc;
    bit          exp_err;
    int          err_cycles;
    bit          did_issue_reset;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[int'((pc >> 2) % DEPTH)];
    endfunction

    task automatic model_reset();
        mode       = M_IDLE;
        wait_n     = 0;
        exp_pc     = RST_PC;
        exp_err    = 1'b0;
        err_cycles = 0;
    endtask

    task automatic model_step();
        case (mode)
            M_IDLE, M_HALT: begin
                if (bus.start) begin
                    mode   = M_RUN;
                    wait_n = 2;
                end
            end
            M_RUN: begin
                if (wait_n > 0) begin
                    wait_n--;
                end else if (bus.inst_ready) begin
                    if (bus.redirect_valid && (bus.redirect_pc % 4 != 0)) begin
                        mode    = M_ERR;
                        exp_err = 1'b1;
                    end else begin
                        exp_pc = bus.redirect_valid ? bus.redirect_pc : exp_pc + 32'd4;
                        if (bus.halt_req) mode = M_HALT;
                        else              wait_n = 2;
                    end
                end
            end
            default: err_cycles++;
        endcase
    endtask

    task automatic check_outputs();
        bit v, r;
        v = (mode == M_RUN) && (wait_n == 0);
        r = (mode == M_RUN) && (wait_n == 2);
        expect_eq("status{valid,ren,halted,err}",
                  {28'b0, bus.inst_valid, bus.imem_ren, bus.halted, bus.misalign_err},
                  {28'b0, v, r, (mode == M_HALT), exp_err});
        expect_eq("pc_out", bus.pc_out, exp_pc);
        expect_eq("imem_addr", 32'(bus.imem_addr), (exp_pc >> 2) % DEPTH);
        if (v) begin
            expect_eq("inst_out", bus.inst_out, word_at(exp_pc));
            expect_eq("pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
        end
    endtask

    task automatic clear_inputs();
        bus.start          = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt_req       = 1'b0;
    endtask

    initial begin
        bit          found;
        bit          issuing;
        logic [31:0] target;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        clear_inputs();
        wbus.start          = 1'b0;
        wbus.inst_ready     = 1'b0;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = 32'h0;
        wbus.halt_req       = 1'b0;
        did_issue_reset     = 1'b0;
        model_reset();

        repeat (2) @(negedge clck);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clck);
            check_outputs();
            issuing = (mode == M_RUN) && (wait_n == 0);
            if ((!did_issue_reset && issuing && cyc > 40) ||
                (mode == M_ERR && err_cycles > 5) ||
                ($urandom_range(0, 399) == 0)) begin
                // Asynchronous reset in the middle of the cycle; outputs must clear at once.
                clear_inputs();
                #2 rst_n = 1'b0;
                #1;
                expect_eq("rst_status", {28'b0, bus.inst_valid, bus.imem_ren, bus.halted, bus.misalign_err}, 32'h0);
                expect_eq("rst_pc_out", bus.pc_out, RST_PC);
                expect_eq("rst_inst_out", bus.inst_out, 32'h0);
                if (issuing) did_issue_reset = 1'b1;
                @(negedge clck);
                rst_n = 1'b1;
                model_reset();
            end else begin
                bus.start      = ($urandom_range(0, 2) == 0);
                bus.inst_ready = (cyc < 30) ? 1'b1 : ($urandom_range(0, 2) != 0);
                bus.redirect_valid = (cyc >= 30) && ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 15))
                    0:       target = ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
                    1:       target = 32'hFFFF_FFFC;
                    default: target = $urandom & ~32'h3;
                endcase
                bus.redirect_pc = target;
                bus.halt_req    = (cyc >= 30) && ($urandom_range(0, 7) == 0);
                model_step();
            end
        end

        // PC wrap: the instance reset to the last word must issue 0xFFFF_FFFC then 0.
        @(negedge clck);
        clear_inputs();
        wbus.start      = 1'b1;
        wbus.inst_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clck);
            if (wbus.inst_valid) found = 1'b1;
        end
        expect_eq("wrap_first_issue_seen", 32'(found), 32'd1);
        if (found) begin
            expect_eq("wrap_first_pc", wbus.pc_out, 32'hFFFF_FFFC);
            expect_eq("wrap_pc_plus4", wbus.pc_plus4, 32'h0);
            expect_eq("wrap_first_inst", wbus.inst_out, word_at(32'hFFFF_FFFC));
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clck);
            if (wbus.inst_valid) found = 1'b1;
        end
        expect_eq("wrap_second_issue_seen", 32'(found), 32'd1);
        if (found) begin
            expect_eq("wrap_second_pc", wbus.pc_out, 32'h0);
            expect_eq("wrap_second_inst", wbus.inst_out, word_at(32'h0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
